// File: rtl/uart_stim_pkg.sv
// Shared types and parameter checks for the UART stimulus driver.
package uart_stim_pkg;

    typedef enum logic [1:0] {
        PAR_NONE = 2'd0,
        PAR_EVEN = 2'd1,
        PAR_ODD  = 2'd2
    } parity_e;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } tx_state_e;

    function automatic bit params_legal(input int clks_per_bit, input int data_bits,
                                        input int parity_mode, input int stop_bits,
                                        input int fifo_depth, input int timeout_cycles);
        return (clks_per_bit >= 2)
            && (data_bits >= 5) && (data_bits <= 9)
            && (parity_mode >= 0) && (parity_mode <= 2)
            && ((stop_bits == 1) || (stop_bits == 2))
            && (fifo_depth >= 2) && ((fifo_depth & (fifo_depth - 1)) == 0)
            && (timeout_cycles >= 0);
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with a registered occupancy count; reads see only stored entries.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_wr_en,
    input  logic [WIDTH-1:0]         i_wr_data,
    input  logic                     i_rd_en,
    output logic [WIDTH-1:0]         o_rd_data,
    output logic [$clog2(DEPTH):0]   o_level,
    output logic                     o_wr_ready
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [AW:0]      level_q;
    logic             push;
    logic             pop;

    // Ready depends on the stored level only, so a pop at full cannot admit a push.
    assign o_wr_ready = (level_q < FULL_LVL);
    assign push       = i_wr_en & o_wr_ready;
    assign pop        = i_rd_en & (level_q != '0);
    assign o_rd_data  = mem[rd_ptr_q];
    assign o_level    = level_q;

    always_ff @(posedge i_clk) begin
        if (push)
            mem[wr_ptr_q] <= i_wr_data;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (push)
                wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)
                rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({push, pop})
                2'b10:   level_q <= level_q + 1'b1;
                2'b01:   level_q <= level_q - 1'b1;
                default: level_q <= level_q;
            endcase
        end
    end

endmodule

// File: rtl/uart_stim_driver.sv
// FIFO-buffered UART frame generator driving a CPU receive line, with a sticky run-length watchdog.
// state  | meaning
// IDLE   | line high, waiting for a stored byte
// START  | start bit (line low)
// DATA   | payload bits, LSB first
// PARITY | optional parity bit
// STOP   | one or two stop bits (line high)
module uart_stim_driver import uart_stim_pkg::*; #(
    parameter int CLKS_PER_BIT   = 868,
    parameter int DATA_BITS      = 8,
    parameter int PARITY_MODE    = 0,
    parameter int STOP_BITS      = 1,
    parameter int FIFO_DEPTH     = 16,
    parameter int TIMEOUT_CYCLES = 0
) (
    input  logic                          i_clk,
    input  logic                          i_rst,
    input  logic                          i_wr_valid,
    input  logic [DATA_BITS-1:0]          i_wr_data,
    output logic                          o_wr_ready,
    output logic                          o_uart_tx,
    output logic                          o_busy,
    output logic [$clog2(FIFO_DEPTH):0]   o_fifo_level,
    output logic [15:0]                   o_frames_sent,
    output logic                          o_timeout
);

    localparam int                LVL_W     = $clog2(FIFO_DEPTH) + 1;
    localparam int                BAUD_W    = $clog2(CLKS_PER_BIT);
    localparam logic [BAUD_W-1:0] BAUD_LOAD = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [3:0]        DATA_LAST = 4'(DATA_BITS - 1);
    localparam logic [3:0]        STOP_LAST = 4'(STOP_BITS - 1);
    localparam parity_e           PAR_CFG   = parity_e'(PARITY_MODE);
    localparam logic [31:0]       WD_LAST   = 32'(TIMEOUT_CYCLES - 1);

    if (!params_legal(CLKS_PER_BIT, DATA_BITS, PARITY_MODE, STOP_BITS, FIFO_DEPTH,
                      TIMEOUT_CYCLES)) begin : g_bad_params
        $error("uart_stim_driver: illegal parameter set");
    end

    tx_state_e            state_q, state_d;
    logic [BAUD_W-1:0]    baud_q, baud_d;
    logic [3:0]           bit_q, bit_d;
    logic [DATA_BITS-1:0] shreg_q, shreg_d;
    logic                 par_q, par_d;
    logic [15:0]          frames_q;
    logic [31:0]          wd_cnt_q;
    logic                 timeout_q;
    logic                 wd_hit;
    logic                 pop;
    logic                 frame_done;
    logic                 baud_tick;
    logic                 fifo_nonempty;
    logic [DATA_BITS-1:0] head;
    logic [LVL_W-1:0]     level;

    sync_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_wr_en    (i_wr_valid),
        .i_wr_data  (i_wr_data),
        .i_rd_en    (pop),
        .o_rd_data  (head),
        .o_level    (level),
        .o_wr_ready (o_wr_ready)
    );

    assign fifo_nonempty = (level != '0);

    always_comb begin
        state_d    = state_q;
        baud_d     = baud_q;
        bit_d      = bit_q;
        shreg_d    = shreg_q;
        par_d      = par_q;
        pop        = 1'b0;
        frame_done = 1'b0;
        baud_tick  = (baud_q == '0);
        if (state_q != IDLE)
            baud_d = baud_tick ? BAUD_LOAD : baud_q - 1'b1;
        case (state_q)
            IDLE: begin
                if (fifo_nonempty) begin
                    pop     = 1'b1;
                    state_d = START;
                    baud_d  = BAUD_LOAD;
                end
            end
            START: begin
                if (baud_tick) begin
                    state_d = DATA;
                    bit_d   = DATA_LAST;
                end
            end
            DATA: begin
                if (baud_tick) begin
                    shreg_d = shreg_q >> 1;
                    if (bit_q == '0) begin
                        state_d = (PAR_CFG != PAR_NONE) ? PARITY : STOP;
                        bit_d   = STOP_LAST;
                    end else begin
                        bit_d = bit_q - 1'b1;
                    end
                end
            end
            PARITY: begin
                if (baud_tick) begin
                    state_d = STOP;
                    bit_d   = STOP_LAST;
                end
            end
            STOP: begin
                if (baud_tick) begin
                    if (bit_q == '0) begin
                        frame_done = 1'b1;
                        // Chain straight into the next start bit when more data is waiting.
                        if (fifo_nonempty) begin
                            pop     = 1'b1;
                            state_d = START;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        bit_d = bit_q - 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        if (pop) begin
            shreg_d = head;
            par_d   = (^head) ^ (PAR_CFG == PAR_ODD);
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q  <= IDLE;
            baud_q   <= '0;
            bit_q    <= '0;
            shreg_q  <= '0;
            par_q    <= 1'b0;
            frames_q <= '0;
        end else begin
            state_q  <= state_d;
            baud_q   <= baud_d;
            bit_q    <= bit_d;
            shreg_q  <= shreg_d;
            par_q    <= par_d;
            if (frame_done)
                frames_q <= frames_q + 1'b1;
        end
    end

    // Decoded from registered state so an async reset returns the line high at once.
    always_comb begin
        o_uart_tx = 1'b1;
        case (state_q)
            START:   o_uart_tx = 1'b0;
            DATA:    o_uart_tx = shreg_q[0];
            PARITY:  o_uart_tx = par_q;
            default: o_uart_tx = 1'b1;
        endcase
    end

    assign wd_hit = (TIMEOUT_CYCLES != 0) && (wd_cnt_q == WD_LAST);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            wd_cnt_q  <= '0;
            timeout_q <= 1'b0;
        end else begin
            if (wd_cnt_q != '1)
                wd_cnt_q <= wd_cnt_q + 1'b1;
            if (wd_hit)
                timeout_q <= 1'b1;
        end
    end

    assign o_timeout     = timeout_q | wd_hit;
    assign o_busy        = (state_q != IDLE) | fifo_nonempty;
    assign o_fifo_level  = level;
    assign o_frames_sent = frames_q;

endmodule

// File: tb/tb_uart_stim_driver.sv
// Directed bench: three driver instances (8N1 with watchdog, 8E2, 8O2) at 4 clocks per bit.
module tb_uart_stim_driver;

    typedef logic bitseq_t [12];

    logic        clk = 1'b0;
    logic        rst;
    logic        valid  [3];
    logic [7:0]  data   [3];
    logic        ready  [3];
    logic        tx     [3];
    logic        busy   [3];
    logic        to     [3];
    logic [2:0]  level  [3];
    logic [15:0] frames [3];

    logic [2:0]  rec [$];
    int          n_checks = 0;
    int          n_pass   = 0;
    int          accepted;
    int          base;

    always #5 clk = ~clk;

    uart_stim_driver #(.CLKS_PER_BIT(4), .DATA_BITS(8), .PARITY_MODE(0), .STOP_BITS(1),
                       .FIFO_DEPTH(4), .TIMEOUT_CYCLES(50)) u_n81 (
        .i_clk(clk), .i_rst(rst), .i_wr_valid(valid[0]), .i_wr_data(data[0]),
        .o_wr_ready(ready[0]), .o_uart_tx(tx[0]), .o_busy(busy[0]), .o_fifo_level(level[0]),
        .o_frames_sent(frames[0]), .o_timeout(to[0]));

    uart_stim_driver #(.CLKS_PER_BIT(4), .DATA_BITS(8), .PARITY_MODE(1), .STOP_BITS(2),
                       .FIFO_DEPTH(4), .TIMEOUT_CYCLES(0)) u_e82 (
        .i_clk(clk), .i_rst(rst), .i_wr_valid(valid[1]), .i_wr_data(data[1]),
        .o_wr_ready(ready[1]), .o_uart_tx(tx[1]), .o_busy(busy[1]), .o_fifo_level(level[1]),
        .o_frames_sent(frames[1]), .o_timeout(to[1]));

    uart_stim_driver #(.CLKS_PER_BIT(4), .DATA_BITS(8), .PARITY_MODE(2), .STOP_BITS(2),
                       .FIFO_DEPTH(4), .TIMEOUT_CYCLES(0)) u_o82 (
        .i_clk(clk), .i_rst(rst), .i_wr_valid(valid[2]), .i_wr_data(data[2]),
        .o_wr_ready(ready[2]), .o_uart_tx(tx[2]), .o_busy(busy[2]), .o_fifo_level(level[2]),
        .o_frames_sent(frames[2]), .o_timeout(to[2]));

    // Line history: one sample per clock, taken just after each rising edge.
    always @(posedge clk) begin
        #1;
        rec.push_back({tx[2], tx[1], tx[0]});
    end

    task automatic check_eq(input string tag, input logic [63:0] observed,
                            input logic [63:0] expected);
        n_checks++;
        if (observed === expected)
            n_pass++;
        else
            $display("FAIL %s: observed %0h expected %0h", tag, observed, expected);
    endtask

    function automatic logic [63:0] wave_at(input int idx, input int start, input int len);
        logic [63:0] w = '0;
        for (int k = 0; k < len; k++)
            w[k] = (start + k < rec.size()) ? rec[start + k][idx] : 1'bx;
        return w;
    endfunction

    function automatic logic [63:0] frame_wave_8n1(input logic [7:0] d);
        logic [9:0]  bits;
        logic [63:0] w = '0;
        bits = {1'b1, d, 1'b0};
        for (int b = 0; b < 10; b++)
            for (int j = 0; j < 4; j++)
                w[b*4 + j] = bits[b];
        return w;
    endfunction

    task automatic check_bits(input string tag, input int idx, input int start,
                              input bitseq_t seq, input int nb);
        for (int b = 0; b < nb; b++)
            check_eq($sformatf("%s bit%0d", tag, b), wave_at(idx, start + 4*b, 4), {4{seq[b]}});
    endtask

    task automatic single_frame(input string tag, input int idx, input logic [7:0] d,
                                input bitseq_t seq, input int nb, input int exp_frames);
        int b0;
        @(negedge clk);
        b0         = rec.size();
        valid[idx] = 1'b1;
        data[idx]  = d;
        @(negedge clk);
        valid[idx] = 1'b0;
        repeat (4*nb + 4) @(negedge clk);
        check_eq({tag, " latency"}, wave_at(idx, b0, 1), 64'd1);
        check_bits(tag, idx, b0 + 1, seq, nb);
        check_eq({tag, " tail"}, wave_at(idx, b0 + 1 + 4*nb, 1), 64'd1);
        check_eq({tag, " frames"}, frames[idx], 64'(exp_frames));
        check_eq({tag, " busy"}, busy[idx], 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: observed running expected finished");
        $fatal(1, "bench time limit exceeded");
    end

    initial begin
        bitseq_t seq_a5;
        bitseq_t seq_e07;
        bitseq_t seq_o07;
        bitseq_t seq_5a;
        seq_a5  = '{0, 1,0,1,0,0,1,0,1, 1, 1,1};
        seq_e07 = '{0, 1,1,1,0,0,0,0,0, 1, 1,1};
        seq_o07 = '{0, 1,1,1,0,0,0,0,0, 0, 1,1};
        seq_5a  = '{0, 0,1,0,1,1,0,1,0, 1, 1,1};

        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            valid[i] = 1'b0;
            data[i]  = 8'h00;
        end
        repeat (3) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            check_eq($sformatf("rst tx%0d", i), tx[i], 64'd1);
            check_eq($sformatf("rst busy%0d", i), busy[i], 64'd0);
            check_eq($sformatf("rst ready%0d", i), ready[i], 64'd1);
            check_eq($sformatf("rst level%0d", i), level[i], 64'd0);
            check_eq($sformatf("rst frames%0d", i), frames[i], 64'd0);
            check_eq($sformatf("rst timeout%0d", i), to[i], 64'd0);
        end

        rst = 1'b0;
        for (int c = 1; c <= 100; c++) begin
            @(negedge clk);
            if (c == 48) check_eq("wdog before", to[0], 64'd0);
            if (c == 49) check_eq("wdog rise", to[0], 64'd1);
        end
        check_eq("idle tx", tx[0], 64'd1);
        check_eq("idle busy", busy[0], 64'd0);
        check_eq("idle ready", ready[0], 64'd1);
        check_eq("idle level", level[0], 64'd0);
        check_eq("wdog sticky", to[0], 64'd1);
        check_eq("wdog off e82", to[1], 64'd0);
        check_eq("wdog off o82", to[2], 64'd0);

        single_frame("n81 a5", 0, 8'hA5, seq_a5, 10, 1);
        single_frame("e82 07", 1, 8'h07, seq_e07, 12, 1);
        single_frame("o82 07", 2, 8'h07, seq_o07, 12, 1);

        // Burst: one byte, then six more on consecutive cycles; four fit behind the first.
        @(negedge clk);
        base     = rec.size();
        accepted = 0;
        valid[0] = 1'b1;
        data[0]  = 8'h11;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            data[0] = 8'h12 + 8'(k);
            if (ready[0]) accepted++;
        end
        @(negedge clk);
        valid[0] = 1'b0;
        check_eq("burst accepted", 64'(accepted), 64'd4);
        check_eq("burst level", level[0], 64'd4);
        check_eq("burst ready", ready[0], 64'd0);
        repeat (200) @(negedge clk);
        check_eq("burst lead", wave_at(0, base, 1), 64'd1);
        for (int k = 0; k < 5; k++)
            check_eq($sformatf("burst frame%0d", k), wave_at(0, base + 1 + 40*k, 40),
                     frame_wave_8n1(8'h11 + 8'(k)));
        check_eq("burst tail", wave_at(0, base + 201, 1), 64'd1);
        check_eq("burst frames", frames[0], 64'd6);
        check_eq("burst drained", level[0], 64'd0);

        // Reset in the middle of a data bit with one byte still queued.
        @(negedge clk);
        valid[0] = 1'b1;
        data[0]  = 8'h00;
        @(negedge clk);
        data[0]  = 8'h33;
        @(negedge clk);
        valid[0] = 1'b0;
        repeat (5) @(negedge clk);
        check_eq("mid data line", tx[0], 64'd0);
        check_eq("mid data level", level[0], 64'd1);
        #2 rst = 1'b1;
        #1;
        check_eq("mid rst tx", tx[0], 64'd1);
        check_eq("mid rst level", level[0], 64'd0);
        check_eq("mid rst busy", busy[0], 64'd0);
        check_eq("mid rst frames", frames[0], 64'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("post rst idle", tx[0], 64'd1);
        single_frame("post rst 5a", 0, 8'h5A, seq_5a, 10, 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
